// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: parametrised pipeline boundary register with valid/ready
// flow control, flush, bubble (NOP) insertion, occupancy and a saturating
// stall-cycle counter for performance debug.
module pipe_stage_latch #(
  parameter int                 WIDTH     = 32,
  parameter int                 STAGES    = 1,
  parameter logic [WIDTH-1:0]   NOP_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [2:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Number of set bits in the stage-valid vector.
  function automatic logic [2:0] popcount(input logic [STAGES-1:0] bits);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < STAGES; i++) begin
      n = n + {2'b00, bits[i]};
    end
    return n;
  endfunction

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d [STAGES];
  logic              in_acc;
  logic              stall_now;

  // Ready chain: a stage can load when it, or any stage after it, is empty,
  // or when downstream accepts. Built with an accumulator so no bit of rdy
  // depends on another bit of the same vector.
  always_comb begin
    logic acc;
    rdy = {STAGES{1'b0}};
    acc = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = acc | ~v[i];
      rdy[i] = acc;
    end
  end

  // in_ready is held low during reset and during a flush cycle.
  assign in_ready = rdy[0] & ~flush & rst_n;
  assign in_acc   = in_valid & in_ready;

  // Source of each stage's next value: stage 0 from the input (NOP when no
  // transfer), every later stage from its predecessor.
  always_comb begin
    src_v[0] = in_acc;
    if (in_acc) begin
      src_d[0] = in_data;
    end else begin
      src_d[0] = NOP_VALUE;
    end
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  // Stage registers: async reset, flush clears everything, otherwise a stage
  // advances only when its ready bit is set. Empty stages always carry NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= NOP_VALUE;
      end
    end else if (flush) begin
      v <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= NOP_VALUE;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= src_v[i];
          d[i] <= src_d[i];
        end else begin
          v[i] <= v[i];
          d[i] <= d[i];
        end
      end
    end
  end

  // A stall is backpressure on a valid output; a flush edge kills the
  // output instead of stalling it, so it is not counted.
  assign stall_now = v[STAGES-1] & ~out_ready & ~flush;

  // Saturating stall counter; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (stall_clr) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (stall_now && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign occupancy = popcount(v);

endmodule
